// File: rtl/carry_resolve_buffer_pkg.sv
// Shared types and constants for the entropy encoder carry-resolve stage:
// FSM encoding, fill pattern selects and the lane word field layout.
package entropy_encoder_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FINAL = 2'd2
    } crb_state_e;

    // Fill pattern select: the run of pending 0xFF bytes is emitted either as
    // all-zero (a carry rippled through it) or all-ones (no carry arrived).
    localparam logic FILL_ZERO = 1'b0;
    localparam logic FILL_ONES = 1'b1;

    // Lane word layout: byte in the low bits, carry flag directly above it.
    localparam int LANE_BYTE_LSB   = 0;
    localparam int LANE_CARRY_BITS = 1;

    function automatic int lane_field_width(input int byte_width);
        return byte_width + LANE_CARRY_BITS;
    endfunction

endpackage

// File: rtl/carry_resolve_buffer_if.sv
// Input-beat and output-byte bus of the carry-resolve buffer; master is the
// producer/consumer side, slave is the buffer itself.
interface carry_resolve_buffer_if #(
    parameter int IN_LANES          = 2,
    parameter int INPUT_DATA_WIDTH  = 16,
    parameter int OUTPUT_DATA_WIDTH = 8
);
    localparam int CNT_W = $clog2(IN_LANES + 1);

    // Handshake: a transfer happens on a clock edge where valid && ready are
    // both high; valid and its payload stay stable until that edge, and ready
    // never depends combinationally on valid of the same channel.
    logic                                 in_valid;
    logic                                 in_ready;
    logic [CNT_W-1:0]                     in_count;
    logic [IN_LANES*INPUT_DATA_WIDTH-1:0] in_words;
    logic                                 in_final;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [OUTPUT_DATA_WIDTH-1:0]         out_byte;
    logic                                 out_last;

    modport master (
        output in_valid, in_count, in_words, in_final, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  in_valid, in_count, in_words, in_final, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );

endinterface

// File: rtl/carry_byte_fifo.sv
// Synchronous FIFO for resolved bytes; push is accepted when full if a pop
// happens in the same cycle. Head holds the last popped entry while empty.
module carry_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/carry_resolve_buffer.sv
// Carry-resolve buffer: holds one byte plus a run of pending 0xFF bytes until
// the carry outcome is known, then emits them into the output FIFO.
// Optional statistics counters are built when CARRY_STATS_EN is defined.
module carry_resolve_buffer
    import entropy_encoder_pkg::*;
#(
    parameter int IN_LANES          = 2,
    parameter int INPUT_DATA_WIDTH  = 16,
    parameter int OUTPUT_DATA_WIDTH = 8,
    parameter int RUN_CNT_WIDTH     = 16,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                  top_clk,
    input  logic                  top_reset_n,
    carry_resolve_buffer_if.slave bus,
    output logic                  done,
    output logic                  busy,
    output logic [1:0]            err,
    output crb_state_e            dbg_state
`ifdef CARRY_STATS_EN
    ,
    output logic [31:0]           stat_bytes,
    output logic [15:0]           stat_carries
`endif
);
    localparam int OW    = OUTPUT_DATA_WIDTH;
    localparam int LW    = lane_field_width(OUTPUT_DATA_WIDTH);
    localparam int CNT_W = $clog2(IN_LANES + 1);
    localparam int IDX_W = (IN_LANES > 1) ? $clog2(IN_LANES) : 1;
    localparam logic [CNT_W-1:0]         LANE_ONE = CNT_W'(1);
    localparam logic [RUN_CNT_WIDTH-1:0] CNT_ONE  = RUN_CNT_WIDTH'(1);
    localparam logic [RUN_CNT_WIDTH-1:0] CNT_MAX  = '1;

    // Lane buffer: only the byte and carry fields of each word are kept.
    logic [LW-1:0]            lane_q [IN_LANES];
    logic [CNT_W-1:0]         lane_rem_q;
    logic [IDX_W-1:0]         lane_idx_q;
    logic                     final_q;

    crb_state_e               state_q;
    logic                     hold_v_q;
    logic [OW-1:0]            hold_q;
    logic [OW-1:0]            nxt_q;
    logic                     fill_ones_q;
    logic                     first_q;
    logic [RUN_CNT_WIDTH-1:0] cnt_q;
    logic                     done_q;
    logic [1:0]               err_q;

    logic [LW-1:0]            cur_lane;
    logic [OW-1:0]            cur_b;
    logic                     cur_c;
    logic                     consume;
    logic                     accept;
    logic                     pushing;
    logic                     push;
    logic                     push_end;
    logic                     push_last;
    logic [OW-1:0]            push_byte;
    logic [OW:0]              fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;

    assign cur_lane = lane_q[lane_idx_q];
    assign cur_b    = cur_lane[LANE_BYTE_LSB +: OW];
    assign cur_c    = cur_lane[OW];

    assign consume  = (state_q == ST_RUN) && (lane_rem_q != '0);
    // Refill is possible when the buffer is idle or its last lane leaves now;
    // an accepted final beat blocks new input until the frame is done.
    assign bus.in_ready = !final_q &&
                          ((lane_rem_q == '0) || (consume && (lane_rem_q == LANE_ONE)));
    assign accept       = bus.in_valid && bus.in_ready;

    assign fifo_pop  = bus.out_ready && !fifo_empty;
    assign pushing   = (state_q == ST_FLUSH) || ((state_q == ST_FINAL) && hold_v_q);
    assign push      = pushing && (!fifo_full || fifo_pop);
    assign push_end  = first_q ? (cnt_q == '0) : (cnt_q == CNT_ONE);
    assign push_byte = first_q ? hold_q : {OW{fill_ones_q}};
    assign push_last = (state_q == ST_FINAL) && push_end;

    always_ff @(posedge top_clk or negedge top_reset_n) begin
        if (!top_reset_n) begin
            for (int k = 0; k < IN_LANES; k++) begin
                lane_q[k] <= '0;
            end
            lane_rem_q  <= '0;
            lane_idx_q  <= '0;
            final_q     <= 1'b0;
            state_q     <= ST_RUN;
            hold_v_q    <= 1'b0;
            hold_q      <= '0;
            nxt_q       <= '0;
            fill_ones_q <= FILL_ZERO;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (consume) begin
                        lane_rem_q <= lane_rem_q - LANE_ONE;
                        lane_idx_q <= lane_idx_q + 1'b1;
                        if (!hold_v_q) begin
                            hold_q   <= cur_b;
                            hold_v_q <= 1'b1;
                            if (cur_c) begin
                                err_q[1] <= 1'b1;
                            end
                        end else if (cur_c) begin
                            // Carry lands on the held byte; the 0xFF run wraps to 0x00.
                            hold_q      <= hold_q + 1'b1;
                            fill_ones_q <= FILL_ZERO;
                            nxt_q       <= cur_b;
                            first_q     <= 1'b1;
                            state_q     <= ST_FLUSH;
                        end else if (&cur_b) begin
                            if (cnt_q == CNT_MAX) begin
                                err_q[0] <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end else begin
                            fill_ones_q <= FILL_ONES;
                            nxt_q       <= cur_b;
                            first_q     <= 1'b1;
                            state_q     <= ST_FLUSH;
                        end
                    end else if (final_q) begin
                        fill_ones_q <= FILL_ONES;
                        first_q     <= 1'b1;
                        state_q     <= ST_FINAL;
                    end
                end
                ST_FLUSH, ST_FINAL: begin
                    if ((state_q == ST_FINAL) && !hold_v_q) begin
                        done_q  <= 1'b1;
                        final_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end else if (push) begin
                        first_q <= 1'b0;
                        if (!first_q) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                        if (push_end) begin
                            cnt_q   <= '0;
                            state_q <= ST_RUN;
                            if (state_q == ST_FLUSH) begin
                                hold_q <= nxt_q;
                            end else begin
                                hold_v_q <= 1'b0;
                                final_q  <= 1'b0;
                                done_q   <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= ST_RUN;
            endcase
            if (accept) begin
                for (int k = 0; k < IN_LANES; k++) begin
                    lane_q[k] <= bus.in_words[k*INPUT_DATA_WIDTH +: LW];
                end
                lane_rem_q <= bus.in_count;
                lane_idx_q <= '0;
                if (bus.in_final) begin
                    final_q <= 1'b1;
                end
            end
        end
    end

    carry_byte_fifo #(
        .WIDTH (OW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (top_clk),
        .rst_ni      (top_reset_n),
        .push_i      (push),
        .push_data_i ({push_last, push_byte}),
        .pop_i       (bus.out_ready),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_byte  = fifo_head[OW-1:0];
    assign bus.out_last  = fifo_head[OW];

    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;
    assign busy      = (lane_rem_q != '0) || final_q || hold_v_q || (state_q != ST_RUN);

`ifdef CARRY_STATS_EN
    logic [31:0] stat_bytes_q;
    logic [15:0] stat_carries_q;

    always_ff @(posedge top_clk or negedge top_reset_n) begin
        if (!top_reset_n) begin
            stat_bytes_q   <= '0;
            stat_carries_q <= '0;
        end else begin
            if (push && (stat_bytes_q != '1)) begin
                stat_bytes_q <= stat_bytes_q + 1'b1;
            end
            if (consume && hold_v_q && cur_c && (stat_carries_q != '1)) begin
                stat_carries_q <= stat_carries_q + 1'b1;
            end
        end
    end

    assign stat_bytes   = stat_bytes_q;
    assign stat_carries = stat_carries_q;
`endif

endmodule

// File: tb/tb_carry_resolve_buffer.sv
// Directed bench for carry_resolve_buffer: a table of whole streams with
// hand-computed output bytes, plus stall and mid-flush reset sequences.
module tb_carry_resolve_buffer;
    import entropy_encoder_pkg::*;

    localparam int NV = 8;

    typedef struct packed {
        logic [3:0]       n_in;
        logic [5:0][15:0] w;
        logic [3:0]       n_out;
        logic [5:0][7:0]  b;
        logic [1:0]       err;
    } vec_t;

    logic        top_clk;
    logic        top_reset_n;
    logic        done;
    logic        busy;
    logic [1:0]  err;
    crb_state_e  dbg_state;
`ifdef CARRY_STATS_EN
    logic [31:0] stat_bytes;
    logic [15:0] stat_carries;
`endif

    int          tests_run;
    int          tests_failed;
    int          done_cnt;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_e;
    vec_t        vecs [NV];

    carry_resolve_buffer_if #(
        .IN_LANES(2), .INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(8)
    ) bus ();

    carry_resolve_buffer #(
        .IN_LANES(2), .INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(8),
        .RUN_CNT_WIDTH(2), .FIFO_DEPTH(4)
    ) dut (
        .top_clk     (top_clk),
        .top_reset_n (top_reset_n),
        .bus         (bus),
        .done        (done),
        .busy        (busy),
        .err         (err),
        .dbg_state   (dbg_state)
`ifdef CARRY_STATS_EN
        ,
        .stat_bytes   (stat_bytes),
        .stat_carries (stat_carries)
`endif
    );

    // Clock / reset
    initial top_clk = 1'b0;
    always #5 top_clk = ~top_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every popped byte must match the head of exp_q
    always @(negedge top_clk) begin
        if (top_reset_n) begin
            if (done) done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL out_byte: got %0h last %0b, required no byte", bus.out_byte, bus.out_last);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({bus.out_last, bus.out_byte} !== exp_e) begin
                        tests_failed++;
                        $display("FAIL out_byte: got %0h last %0b, required %0h last %0b",
                                 bus.out_byte, bus.out_last, exp_e[7:0], exp_e[8]);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic drive_beat(input int cnt, input logic [31:0] words, input logic fin);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_count = 2'(cnt);
        bus.in_words = words;
        bus.in_final = fin;
        for (int k = 0; k < 200; k++) begin
            @(negedge top_clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge top_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_count = '0;
        bus.in_final = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL in_ready: got 0 for 200 cycles, required 1");
        end
    endtask

    task automatic send_stream(input vec_t vv);
        if (vv.n_in == 0) begin
            drive_beat(0, 32'h0, 1'b1);
        end else begin
            for (int i = 0; i < int'(vv.n_in); i += 2) begin
                if (i + 1 < int'(vv.n_in))
                    drive_beat(2, {vv.w[i+1], vv.w[i]}, (i + 2 >= int'(vv.n_in)));
                else
                    drive_beat(1, {16'h0, vv.w[i]}, 1'b1);
            end
        end
    endtask

    task automatic wait_done(input int start, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge top_clk);
            if (done_cnt > start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: got no done in 300 cycles, required done", name);
        end
        repeat (4) @(negedge top_clk);
        @(posedge top_clk);
        #1;
    endtask

    initial begin
        int start;
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        top_reset_n  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_count = '0;
        bus.in_words = '0;
        bus.in_final = 1'b0;
        bus.out_ready = 1'b0;

        // Stream table: words in, bytes out (last on final byte), sticky err after
        vecs[0] = '0; vecs[0].n_in = 2; vecs[0].w[0] = 16'hFE12; vecs[0].w[1] = 16'h7034;
        vecs[0].n_out = 2; vecs[0].b[0] = 8'h12; vecs[0].b[1] = 8'h34; vecs[0].err = 2'b00;
        vecs[1] = '0; vecs[1].n_in = 4;
        vecs[1].w[0] = 16'h0012; vecs[1].w[1] = 16'h00FF; vecs[1].w[2] = 16'h00FF; vecs[1].w[3] = 16'h0105;
        vecs[1].n_out = 4;
        vecs[1].b[0] = 8'h13; vecs[1].b[1] = 8'h00; vecs[1].b[2] = 8'h00; vecs[1].b[3] = 8'h05;
        vecs[2] = '0; vecs[2].n_in = 3;
        vecs[2].w[0] = 16'h0012; vecs[2].w[1] = 16'h00FF; vecs[2].w[2] = 16'h0040;
        vecs[2].n_out = 3; vecs[2].b[0] = 8'h12; vecs[2].b[1] = 8'hFF; vecs[2].b[2] = 8'h40;
        vecs[3] = '0;
        vecs[4] = '0; vecs[4].n_in = 3;
        vecs[4].w[0] = 16'h00AB; vecs[4].w[1] = 16'h00FF; vecs[4].w[2] = 16'h01FF;
        vecs[4].n_out = 3; vecs[4].b[0] = 8'hAC; vecs[4].b[1] = 8'h00; vecs[4].b[2] = 8'hFF;
        vecs[5] = '0; vecs[5].n_in = 2; vecs[5].w[0] = 16'h00FF; vecs[5].w[1] = 16'h0100;
        vecs[5].n_out = 2; vecs[5].b[0] = 8'h00; vecs[5].b[1] = 8'h00;
        vecs[6] = '0; vecs[6].n_in = 2; vecs[6].w[0] = 16'h0155; vecs[6].w[1] = 16'h0066;
        vecs[6].n_out = 2; vecs[6].b[0] = 8'h55; vecs[6].b[1] = 8'h66; vecs[6].err = 2'b10;
        vecs[7] = '0; vecs[7].n_in = 5;
        vecs[7].w[0] = 16'h0010; vecs[7].w[1] = 16'h00FF; vecs[7].w[2] = 16'h00FF;
        vecs[7].w[3] = 16'h00FF; vecs[7].w[4] = 16'h00FF;
        vecs[7].n_out = 4; vecs[7].b[0] = 8'h10; vecs[7].b[1] = 8'hFF;
        vecs[7].b[2] = 8'hFF; vecs[7].b[3] = 8'hFF; vecs[7].err = 2'b11;

        // Reset state
        repeat (3) @(negedge top_clk);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_byte", bus.out_byte, 0);
        check("rst out_last", bus.out_last, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst err", err, 0);
        check("rst state", dbg_state, ST_RUN);
        top_reset_n = 1'b1;
        #1;
        check("rst in_ready", bus.in_ready, 1);
        @(posedge top_clk);
        #1;
        bus.out_ready = 1'b1;

        // Table-driven streams
        for (int v = 0; v < NV; v++) begin
            start = done_cnt;
            for (int j = 0; j < int'(vecs[v].n_out); j++)
                exp_q.push_back({(j == int'(vecs[v].n_out) - 1), vecs[v].b[j]});
            send_stream(vecs[v]);
            wait_done(start, $sformatf("vec%0d wait", v));
            check($sformatf("vec%0d done count", v), done_cnt - start, 1);
            check($sformatf("vec%0d bytes left", v), exp_q.size(), 0);
            check($sformatf("vec%0d err", v), err, vecs[v].err);
            check($sformatf("vec%0d busy", v), busy, 0);
            exp_q.delete();
        end

        // FIFO full stall: six lanes with out_ready low, then drain
        bus.out_ready = 1'b0;
        start = done_cnt;
        for (int j = 1; j <= 6; j++) exp_q.push_back({(j == 6), 8'(j)});
        drive_beat(2, {16'h0002, 16'h0001}, 1'b0);
        drive_beat(2, {16'h0004, 16'h0003}, 1'b0);
        drive_beat(2, {16'h0006, 16'h0005}, 1'b0);
        drive_beat(0, 32'h0, 1'b1);
        repeat (10) @(negedge top_clk);
        check("stall in_ready", bus.in_ready, 0);
        check("stall busy", busy, 1);
        check("stall out_valid", bus.out_valid, 1);
        check("stall state", dbg_state, ST_FLUSH);
        check("stall bytes held", exp_q.size(), 6);
        @(posedge top_clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done(start, "stall wait");
        check("stall done count", done_cnt - start, 1);
        check("stall bytes left", exp_q.size(), 0);
        exp_q.delete();

        // Reset in the middle of flushing a 3-byte run
        bus.out_ready = 1'b0;
        drive_beat(2, {16'h00FF, 16'h0012}, 1'b0);
        drive_beat(2, {16'h0034, 16'h00FF}, 1'b0);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge top_clk);
                if (dbg_state == ST_FLUSH) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("reset flush reached", seen, 1);
        end
        @(posedge top_clk);
        @(negedge top_clk);
        top_reset_n = 1'b0;
        #1;
        check("mid rst out_valid", bus.out_valid, 0);
        check("mid rst out_byte", bus.out_byte, 0);
        check("mid rst out_last", bus.out_last, 0);
        check("mid rst busy", busy, 0);
        check("mid rst err", err, 0);
        check("mid rst done", done, 0);
        exp_q.delete();
        repeat (2) @(negedge top_clk);
        top_reset_n = 1'b1;
        @(posedge top_clk);
        #1;
        bus.out_ready = 1'b1;
        start = done_cnt;
        exp_q.push_back({1'b1, 8'h55});
        drive_beat(1, 32'h0000_0055, 1'b1);
        wait_done(start, "fresh wait");
        check("fresh done count", done_cnt - start, 1);
        check("fresh bytes left", exp_q.size(), 0);
        check("fresh err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/carry_resolve_buffer.md
Name: carry_resolve_buffer

Overview:
- Parametrised successor to the current single-byte carry-propagation stage of the entropy encoder top.
- Accepts up to IN_LANES carry-tagged bitstream words per beat from the arithmetic encoder or the final-bits mux.
- Resolves carries across arbitrarily long 0xFF runs and pushes resolved bytes into an output FIFO with valid/ready handshake.
- Handles the end-of-frame flush and tags the final byte.

Parameters:
- IN_LANES, 2: max words per input beat.
- INPUT_DATA_WIDTH, 16: input word width.
- OUTPUT_DATA_WIDTH, 8: output byte width.
- RUN_CNT_WIDTH, 16: width of the pending-0xFF run counter.
- FIFO_DEPTH, 8: output FIFO entries; power of 2, at least 2.

Ports:
- top_clk  in  1  clock.
- top_reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_count  in  $clog2(IN_LANES+1)  lanes valid in beat; 0 is legal.
- in_words  in  IN_LANES*INPUT_DATA_WIDTH  lane k at [k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]; lane 0 first in stream order.
- in_final  in  1  sampled with the beat; stream ends after this beat's lanes.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer pops on out_valid & out_ready.
- out_byte  out  OUTPUT_DATA_WIDTH  head byte.
- out_last  out  1  head byte is the last of the stream.
- done  out  1  one-cycle pulse when final flush completes.
- busy  out  1  lanes pending, hold valid, or FSM not in RUN.
- err  out  2  sticky; [0] run counter overflow, [1] carry with no held byte.

Behaviour:
- Reset (async assert, sync release):
  - All state cleared; hold_v=0, cnt=0, FSM=RUN.
  - out_valid, out_byte, out_last, done, busy and err are 0.
  - in_ready=1 once reset releases.
- Lane word fields:
  - b = word[OUTPUT_DATA_WIDTH-1:0].
  - c = word[OUTPUT_DATA_WIDTH].
  - Higher bits are ignored.
- Input: accepted lanes are copied into a lane buffer and consumed one per cycle in RUN. in_ready = lane buffer empty, or last lane consumed this cycle with no in_final pending.
- RUN, per lane:
  - hold_v=0: H<=b, hold_v<=1. If c=1, set err[1] and ignore the carry.
  - c=1: H<=H+1 (mod 2^OUTPUT_DATA_WIDTH, no further propagation), fill<=0x00, nxt<=b, go to FLUSH.
  - c=0 and b==0xFF: cnt<=cnt+1. At max, saturate, set err[0], drop the byte.
  - c=0 and b!=0xFF: fill<=0xFF, nxt<=b, go to FLUSH.
- FLUSH:
  - Push H, then cnt copies of fill; one push per cycle, only when FIFO can accept.
  - Takes cnt+1 push cycles. Then H<=nxt, cnt<=0, return to RUN.
- FINAL: entered when in_final is latched and lanes are drained.
  - Pushes H plus cnt×0xFF; the last push has out_last=1.
  - done pulses the cycle after the last push, then hold_v<=0 and FSM goes to RUN.
  - If hold_v=0 at FINAL: nothing is pushed; done pulses the next cycle.
- FIFO:
  - Push is allowed when not full, or when a pop happens the same cycle.
  - Empty means out_valid=0; out_byte/out_last hold their last values.
  - Stored entry is {last, byte}.
  - Latency from lane processing to out_valid is 1 cycle.
- Stall: the FSM holds all state while the FIFO is full; no byte is lost or duplicated.
- in_final with in_count=0 is legal and goes straight to FINAL once drained.
- New beats are not accepted between an accepted in_final and done.

Optional Feature:
- CARRY_STATS_EN defined:
  - Adds output stat_bytes (32, bytes pushed) and output stat_carries (16, carries resolved).
  - Both saturate and clear on reset.
- Undefined: these ports and counters are absent; no other behaviour changes.

Decomposition:
- Package entropy_encoder_pkg holds:
  - FSM state encoding (RUN, FLUSH, FINAL).
  - Fill constants 0x00/0xFF.
  - Lane-field width localparams.
- Sub-module carry_byte_fifo: synchronous FIFO of width OUTPUT_DATA_WIDTH+1, depth FIFO_DEPTH, with full/empty flags and simultaneous push/pop.

Test Plan:
- Lanes 0x012, 0x034, then in_final, out_ready=1 -> bytes 12, 34; last on 34; done pulses once.
- Lanes 0x012, 0x0FF, 0x0FF, 0x105, in_final -> 13, 00, 00, 05; last on 05; err=0.
- Lanes 0x012, 0x0FF, 0x040, in_final -> 12, FF, 40; last on 40.
- FIFO_DEPTH=4, out_ready=0, six non-FF lanes -> in_ready deasserts; out_ready=1 then yields all six bytes in order.
- top_reset_n pulsed low mid-FLUSH of a 3-byte run -> outputs zero immediately; a fresh stream 0x055, final -> 55 with last set.
- RUN_CNT_WIDTH=2, lanes 0x010 then four 0x0FF -> err[0] set on the fourth; final -> 10, FF, FF, FF.
